// File: rtl/sound_mixer_nch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sound_pkg
// Purpose  : Shared register map, FSM state encoding and volume constants for
//            the N-channel stereo mixer.
// Revision : 1.0 - initial release
// ============================================================================
package sound_pkg;

  localparam logic [7:0] MIX_RST      = 8'h00;
  localparam logic [7:0] MIX_VOL_BASE = 8'h40;
  localparam logic [7:0] MIX_STATUS   = 8'h80;
  localparam logic [7:0] MIX_INFO     = 8'h81;

  localparam int VOL_UNITY = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } mix_state_e;

  // Unity gain for an arbitrary volume width: vol / 2^(vw-1) == 1.
  function automatic int vol_unity(input int vw);
    return 1 << (vw - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sound_mixer_nch_if.sv
`default_nettype none
// ============================================================================
// Module   : sound_mixer_nch_if
// Purpose  : Mixer register port, driven by the SB mixer index/data decode.
// Revision : 1.0 - initial release
// ============================================================================
interface sound_mixer_nch_if;

  logic [7:0] reg_idx;
  logic       reg_wr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;

  modport master (
    output reg_idx,
    output reg_wr,
    output reg_wdata,
    input  reg_rdata
  );

  modport slave (
    input  reg_idx,
    input  reg_wr,
    input  reg_wdata,
    output reg_rdata
  );

endinterface
`default_nettype wire

// File: rtl/sound_mixer_nch_mac.sv
`default_nettype none
// ============================================================================
// Module   : sound_mix_mac
// Purpose  : Signed sample x unsigned volume multiply-accumulate, clear/enable.
// Revision : 1.0 - initial release
// ============================================================================
module sound_mix_mac #(
  parameter int IW = 16,
  parameter int VW = 5,
  parameter int AW = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [IW-1:0] smp,
  input  logic        [VW-1:0] vol,
  output logic signed [AW-1:0] acc
);

  logic signed [IW+VW:0] w_prod;
  logic signed [AW-1:0]  r_acc;

  // Zero-extended volume keeps the product signed x unsigned.
  assign w_prod = smp * $signed({1'b0, vol});
  assign acc    = r_acc;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_acc <= '0;
    end else if (en) begin
      r_acc <= r_acc + AW'(w_prod);
    end
  end

endmodule
`default_nettype wire

// File: rtl/sound_mixer_nch.sv
`default_nettype none
// ============================================================================
// Module   : sound_mixer_nch
// Purpose  : N-channel stereo mixer: time-multiplexed MAC, per-channel ramped
//            L/R volume, saturating output with sticky clip/overrun status.
// Revision : 1.0 - initial release
// ============================================================================
module sound_mixer_nch
  import sound_pkg::*;
#(
  parameter int NCH = 4,
  parameter int IW  = 16,
  parameter int OW  = 16,
  parameter int VW  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce_sample,
  input  logic [NCH*IW-1:0] in_l,
  input  logic [NCH*IW-1:0] in_r,
  sound_mixer_nch_if.slave  bus,
  output logic [OW-1:0]     sample_l,
  output logic [OW-1:0]     sample_r,
  output logic              sample_vld,
  output logic              busy
);

  localparam int AW = IW + VW + $clog2(NCH) + 1;
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [VW-1:0]        VOL_INIT = VW'(vol_unity(VW));
  localparam logic signed [AW-1:0] SAT_MAX  = $signed({{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}});
  localparam logic signed [AW-1:0] SAT_MIN  = ~SAT_MAX;

  mix_state_e             r_state;
  logic [CW-1:0]          r_chan;
  logic signed [IW-1:0]   r_snap_l [NCH];
  logic signed [IW-1:0]   r_snap_r [NCH];
  logic [VW-1:0]          r_tgt_l  [NCH];
  logic [VW-1:0]          r_tgt_r  [NCH];
  logic [VW-1:0]          r_cur_l  [NCH];
  logic [VW-1:0]          r_cur_r  [NCH];
  logic                   r_clip_l;
  logic                   r_clip_r;
  logic                   r_overrun;
  logic [7:0]             r_rdata;

  logic signed [IW-1:0]   w_op_l;
  logic signed [IW-1:0]   w_op_r;
  logic [VW-1:0]          w_vol_l;
  logic [VW-1:0]          w_vol_r;
  logic signed [AW-1:0]   w_acc_l;
  logic signed [AW-1:0]   w_acc_r;
  logic signed [AW-1:0]   w_shift_l;
  logic signed [AW-1:0]   w_shift_r;
  logic [OW-1:0]          w_sat_l;
  logic [OW-1:0]          w_sat_r;
  logic                   w_clip_l;
  logic                   w_clip_r;
  logic                   w_start;
  logic                   w_acc_en;
  logic [2:0]             w_st_clr;
  logic [7:0]             w_rdata;
  logic                   w_unused;

  assign w_start  = (r_state == ST_IDLE) && ce_sample;
  assign w_acc_en = (r_state == ST_ACC);
  assign w_st_clr = (bus.reg_wr && bus.reg_idx == MIX_STATUS) ? bus.reg_wdata[2:0] : 3'b000;
  assign w_unused = ^bus.reg_wdata;
  assign bus.reg_rdata = r_rdata;

  always_comb begin
    w_op_l  = '0;
    w_op_r  = '0;
    w_vol_l = '0;
    w_vol_r = '0;
    for (int c = 0; c < NCH; c++) begin
      if (r_chan == CW'(c)) begin
        w_op_l  = r_snap_l[c];
        w_op_r  = r_snap_r[c];
        w_vol_l = r_cur_l[c];
        w_vol_r = r_cur_r[c];
      end
    end
  end

  sound_mix_mac #(.IW(IW), .VW(VW), .AW(AW)) u_mac_l (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_start),
    .en    (w_acc_en),
    .smp   (w_op_l),
    .vol   (w_vol_l),
    .acc   (w_acc_l)
  );

  sound_mix_mac #(.IW(IW), .VW(VW), .AW(AW)) u_mac_r (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_start),
    .en    (w_acc_en),
    .smp   (w_op_r),
    .vol   (w_vol_r),
    .acc   (w_acc_r)
  );

  // Arithmetic shift removes the unity-gain scale, then clamp to OW bits.
  always_comb begin
    w_shift_l = w_acc_l >>> (VW - 1);
    w_shift_r = w_acc_r >>> (VW - 1);
    w_clip_l  = (w_shift_l > SAT_MAX) || (w_shift_l < SAT_MIN);
    w_clip_r  = (w_shift_r > SAT_MAX) || (w_shift_r < SAT_MIN);
    if (w_shift_l > SAT_MAX)      w_sat_l = SAT_MAX[OW-1:0];
    else if (w_shift_l < SAT_MIN) w_sat_l = SAT_MIN[OW-1:0];
    else                          w_sat_l = w_shift_l[OW-1:0];
    if (w_shift_r > SAT_MAX)      w_sat_r = SAT_MAX[OW-1:0];
    else if (w_shift_r < SAT_MIN) w_sat_r = SAT_MIN[OW-1:0];
    else                          w_sat_r = w_shift_r[OW-1:0];
  end

  always_comb begin
    w_rdata = 8'h00;
    if (bus.reg_idx == MIX_STATUS) begin
      w_rdata = {5'b0, r_overrun, r_clip_r, r_clip_l};
    end else if (bus.reg_idx == MIX_INFO) begin
      w_rdata = {4'b0, 4'(NCH - 1)};
    end
    for (int c = 0; c < NCH; c++) begin
      if (bus.reg_idx == 8'(MIX_VOL_BASE + 2*c))     w_rdata = 8'(r_tgt_l[c]);
      if (bus.reg_idx == 8'(MIX_VOL_BASE + 2*c + 1)) w_rdata = 8'(r_tgt_r[c]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_chan     <= '0;
      sample_l   <= '0;
      sample_r   <= '0;
      sample_vld <= 1'b0;
      busy       <= 1'b0;
      r_rdata    <= 8'h00;
      r_clip_l   <= 1'b0;
      r_clip_r   <= 1'b0;
      r_overrun  <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        r_snap_l[c] <= '0;
        r_snap_r[c] <= '0;
        r_tgt_l[c]  <= VOL_INIT;
        r_tgt_r[c]  <= VOL_INIT;
        r_cur_l[c]  <= VOL_INIT;
        r_cur_r[c]  <= VOL_INIT;
      end
    end else begin
      sample_vld <= 1'b0;
      r_rdata    <= w_rdata;

      // Sticky status: a set in the same clock as a clear wins.
      r_clip_l  <= (r_clip_l  & ~w_st_clr[0]) | ((r_state == ST_OUT) && w_clip_l);
      r_clip_r  <= (r_clip_r  & ~w_st_clr[1]) | ((r_state == ST_OUT) && w_clip_r);
      r_overrun <= (r_overrun & ~w_st_clr[2]) | (ce_sample && (r_state != ST_IDLE));

      if (bus.reg_wr) begin
        for (int c = 0; c < NCH; c++) begin
          if (bus.reg_idx == MIX_RST) begin
            r_tgt_l[c] <= VOL_INIT;
            r_tgt_r[c] <= VOL_INIT;
          end
          if (bus.reg_idx == 8'(MIX_VOL_BASE + 2*c))     r_tgt_l[c] <= bus.reg_wdata[VW-1:0];
          if (bus.reg_idx == 8'(MIX_VOL_BASE + 2*c + 1)) r_tgt_r[c] <= bus.reg_wdata[VW-1:0];
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (ce_sample) begin
            for (int c = 0; c < NCH; c++) begin
              r_snap_l[c] <= in_l[c*IW +: IW];
              r_snap_r[c] <= in_r[c*IW +: IW];
            end
            r_chan  <= '0;
            busy    <= 1'b1;
            r_state <= ST_ACC;
          end
        end
        ST_ACC: begin
          if (r_chan == CW'(NCH - 1)) r_state <= ST_OUT;
          else                        r_chan  <= r_chan + 1'b1;
        end
        ST_OUT: begin
          sample_l   <= w_sat_l;
          sample_r   <= w_sat_r;
          sample_vld <= 1'b1;
          busy       <= 1'b0;
          r_state    <= ST_IDLE;
          // Gains creep one step per frame so volume changes never click.
          for (int c = 0; c < NCH; c++) begin
            if (r_cur_l[c] < r_tgt_l[c])      r_cur_l[c] <= r_cur_l[c] + 1'b1;
            else if (r_cur_l[c] > r_tgt_l[c]) r_cur_l[c] <= r_cur_l[c] - 1'b1;
            if (r_cur_r[c] < r_tgt_r[c])      r_cur_r[c] <= r_cur_r[c] + 1'b1;
            else if (r_cur_r[c] > r_tgt_r[c]) r_cur_r[c] <= r_cur_r[c] - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
